// File: rtl/pack_sched_if.sv
// Handshake bundle linking pack_sched to the PE lanes, the byte packer and the output buffer.
// The master side is the scheduler; the slave side is the surrounding datapath.
interface pack_sched_if #(
    parameter int N_PE  = 4,
    parameter int ACC_W = 24
);
    logic [N_PE-1:0]       pe_valid;
    logic [N_PE*ACC_W-1:0] pe_data;
    logic [N_PE-1:0]       pe_ready;
    logic                  pk_in_valid;
    logic [23:0]           pk_in_data;
    logic                  pk_clear;
    logic [31:0]           pk_out_data;
    logic                  word_valid;
    logic [31:0]           word_data;
    logic                  word_ready;

    modport master (
        input  pe_valid, pe_data, pk_out_data, word_ready,
        output pe_ready, pk_in_valid, pk_in_data, pk_clear, word_valid, word_data
    );

    modport slave (
        output pe_valid, pe_data, pk_out_data, word_ready,
        input  pe_ready, pk_in_valid, pk_in_data, pk_clear, word_valid, word_data
    );
endinterface

// File: rtl/pack_sched.sv
// Drains the PE lanes in fixed order, requantizes each accumulator to int8 and sequences
// the byte packer so every completed 32-bit word is offered on a valid/ready port.
module pack_sched #(
    parameter int N_PE    = 4,
    parameter int ACC_W   = 24,
    parameter int SHIFT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [CNT_W-1:0]   cfg_num_words,
    pack_sched_if.master       bus,
    output logic               busy,
    output logic               done
);
    localparam int                     LANE_W    = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(N_PE - 1);
    localparam logic signed [ACC_W:0]  RND_ONE   = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0]  BYTE_MAX  = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0]  BYTE_MIN  = -(ACC_W+1)'(128);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_PAD,
        S_OUT
    } state_t;

    state_t state, state_nx;

    logic [LANE_W-1:0]       lane;
    logic [CNT_W-1:0]        word_cnt;
    logic [CNT_W-1:0]        word_cnt_inc;
    logic [CNT_W-1:0]        num_words_q;
    logic [SHIFT_W-1:0]      shift_q;
    logic                    padded;
    logic                    done_q;
    logic                    job_end;
    logic                    lane_fire;
    logic                    last_word;
    logic signed [ACC_W-1:0] acc_cur;
    logic signed [7:0]       byte_cur;

    // One guard bit above the accumulator keeps the rounding bias from overflowing.
    function automatic logic signed [ACC_W:0] round_shift(
        input logic signed [ACC_W-1:0] acc,
        input logic [SHIFT_W-1:0]      sh
    );
        logic signed [ACC_W:0] r;
        r = (ACC_W+1)'(acc);
        if (sh != '0) r = r + (RND_ONE <<< (sh - SHIFT_W'(1)));
        return r >>> sh;
    endfunction

    function automatic logic signed [7:0] sat_int8(input logic signed [ACC_W:0] v);
        if (v > BYTE_MAX) return 8'sh7f;
        if (v < BYTE_MIN) return 8'sh80;
        return v[7:0];
    endfunction

    assign acc_cur      = bus.pe_data[int'(lane)*ACC_W +: ACC_W];
    assign byte_cur     = sat_int8(round_shift(acc_cur, shift_q));
    assign lane_fire    = (state == S_COLLECT) && !flush && bus.pe_valid[lane];
    assign word_cnt_inc = word_cnt + 1'b1;
    assign last_word    = padded || (word_cnt_inc == num_words_q);
    assign done         = done_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start && (cfg_num_words != '0)) state_nx = S_COLLECT;
            end
            S_COLLECT: begin
                if (flush)                                 state_nx = (lane == '0) ? S_IDLE : S_PAD;
                else if (lane_fire && (lane == LAST_LANE)) state_nx = S_OUT;
            end
            S_PAD: begin
                if (lane == LAST_LANE) state_nx = S_OUT;
            end
            S_OUT: begin
                if (bus.word_ready) state_nx = last_word ? S_IDLE : S_COLLECT;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Everything but pk_clear is forced low while rst is held, even mid-job.
    always_comb begin
        bus.pe_ready    = '0;
        bus.pk_in_valid = 1'b0;
        bus.pk_in_data  = '0;
        bus.pk_clear    = rst;
        bus.word_valid  = 1'b0;
        bus.word_data   = '0;
        busy            = 1'b0;
        job_end         = 1'b0;
        if (!rst) begin
            busy = (state != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    bus.pk_clear = start;
                    job_end      = start && (cfg_num_words == '0);
                end
                S_COLLECT: begin
                    if (flush) begin
                        job_end = (lane == '0);
                    end else begin
                        bus.pe_ready[lane] = 1'b1;
                        bus.pk_in_valid    = bus.pe_valid[lane];
                        bus.pk_in_data     = {16'b0, byte_cur};
                    end
                end
                S_PAD: begin
                    bus.pk_in_valid = 1'b1;
                end
                S_OUT: begin
                    bus.word_valid = 1'b1;
                    bus.word_data  = bus.pk_out_data;
                    bus.pk_clear   = bus.word_ready;
                    job_end        = bus.word_ready && last_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane     <= '0;
            word_cnt <= '0;
            padded   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= job_end;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        lane     <= '0;
                        word_cnt <= '0;
                        padded   <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (flush) begin
                        if (lane != '0) padded <= 1'b1;
                    end else if (lane_fire) begin
                        lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
                    end
                end
                S_PAD: begin
                    lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
                end
                S_OUT: begin
                    if (bus.word_ready) begin
                        word_cnt <= word_cnt_inc;
                        lane     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Job configuration is captured on start and held for the whole job.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && start) begin
            shift_q     <= cfg_shift;
            num_words_q <= cfg_num_words;
        end
    end
endmodule

// File: tb/tb_pack_sched.sv
// Directed bench for pack_sched; a small behavioural byte packer sits on the packer port.
module tb_pack_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [3:0]  cfg_shift;
    logic [15:0] cfg_num_words;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [31:0] pk_word;
    logic [1:0]  pk_ptr;

    typedef struct packed {
        logic [3:0]  shift;
        logic [95:0] pe;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [7];

    pack_sched_if #(.N_PE(4), .ACC_W(24)) bus ();

    pack_sched #(.N_PE(4), .ACC_W(24), .SHIFT_W(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .cfg_shift    (cfg_shift),
        .cfg_num_words(cfg_num_words),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Byte packer: byte i of the word is the i-th write since the last clear.
    always @(posedge clk) begin
        if (bus.pk_clear) begin
            pk_word <= '0;
            pk_ptr  <= '0;
        end else if (bus.pk_in_valid) begin
            pk_word[int'(pk_ptr)*8 +: 8] <= bus.pk_in_data[7:0];
            pk_ptr <= pk_ptr + 2'd1;
        end
    end
    assign bus.pk_out_data = pk_word;

    always @(negedge clk) begin
        total++;
        if (bus.pk_in_valid && bus.pk_clear) begin
            bad++;
            $display("FAIL write_vs_clear: pk_in_valid=%0b pk_clear=%0b, want never both", bus.pk_in_valid, bus.pk_clear);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_word(input string nm, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.word_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_word_valid"}, 32'(bus.word_valid), 32'd1);
    endtask

    // Called at a negedge inside OUT; returns one tick after the accepting edge.
    task automatic accept(input string nm);
        bus.word_ready = 1'b1;
        #1;
        chk({nm, "_accept_clear"}, 32'(bus.pk_clear), 32'd1);
        tick();
        bus.word_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        tick();
        start         = 1'b1;
        cfg_shift     = v.shift;
        cfg_num_words = 16'd1;
        bus.pe_data   = v.pe;
        bus.pe_valid  = '0;
        @(negedge clk);
        chk({tag, "_start_clear"}, 32'(bus.pk_clear), 32'd1);
        tick();
        start        = 1'b0;
        bus.pe_valid = 4'hF;
        wait_word(tag, 20);
        chk({tag, "_word"}, bus.word_data, v.word);
        accept(tag);
        bus.pe_valid = '0;
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    logic [3:0] vmask [8];
    logic [3:0] rmask [8];
    logic       fmask [8];

    initial begin
        vecs[0] = '{shift: 4'd4,  pe: {24'h7FFFFF, 24'hFFFFF8, 24'h000108, 24'h000100}, word: 32'h7F001110};
        vecs[1] = '{shift: 4'd0,  pe: {24'hFFFF38, 24'hFFFF38, 24'hFFFF38, 24'hFFFF38}, word: 32'h80808080};
        vecs[2] = '{shift: 4'd0,  pe: {24'h000005, 24'h000005, 24'h000005, 24'h000005}, word: 32'h05050505};
        vecs[3] = '{shift: 4'd4,  pe: {24'h000018, 24'h000007, 24'h800000, 24'hFFFFF7}, word: 32'h020080FF};
        vecs[4] = '{shift: 4'd15, pe: {24'h003FFF, 24'h004000, 24'hC00000, 24'h7FFFFF}, word: 32'h0001807F};
        vecs[5] = '{shift: 4'd1,  pe: {24'hFFFF00, 24'h0000FF, 24'hFFFFFD, 24'h000003}, word: 32'h807FFF02};
        vecs[6] = '{shift: 4'd0,  pe: {24'hFFFF7F, 24'hFFFF80, 24'h000080, 24'h00007F}, word: 32'h80807F7F};

        vmask = '{4'b1000, 4'b1000, 4'b1010, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
        rmask = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
        fmask = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        rst            = 1'b1;
        start          = 1'b0;
        flush          = 1'b0;
        cfg_shift      = '0;
        cfg_num_words  = '0;
        bus.pe_valid   = '0;
        bus.pe_data    = '0;
        bus.word_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_clear", 32'(bus.pk_clear), 32'd1);
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_pe_ready", 32'(bus.pe_ready), 32'd0);
        chk("rst_in_valid", 32'(bus.pk_in_valid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_clear", 32'(bus.pk_clear), 32'd0);

        // Flush while idle does nothing.
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_busy", 32'(busy), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_done", 32'(done), 32'd0);

        // Zero-length job.
        tick();
        start         = 1'b1;
        cfg_num_words = 16'd0;
        @(negedge clk);
        chk("zero_clear", 32'(bus.pk_clear), 32'd1);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        chk("zero_done_pulse", 32'(done), 32'd0);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Out-of-order lane valids across a two-word job.
        tick();
        start         = 1'b1;
        cfg_shift     = 4'd0;
        cfg_num_words = 16'd2;
        bus.pe_data   = {24'h000044, 24'h000033, 24'h000022, 24'h000011};
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < 8; t++) begin
                tick();
                start        = 1'b0;
                bus.pe_valid = vmask[t];
                @(negedge clk);
                chk($sformatf("ooo_w%0d_t%0d_ready", w, t), 32'(bus.pe_ready), 32'(rmask[t]));
                chk($sformatf("ooo_w%0d_t%0d_fire", w, t), 32'(bus.pk_in_valid), 32'(fmask[t]));
            end
            tick();
            bus.pe_valid = '0;
            wait_word($sformatf("ooo_w%0d", w), 10);
            chk($sformatf("ooo_w%0d_word", w), bus.word_data, (w == 0) ? 32'h44332211 : 32'hFCFDFEFF);
            accept($sformatf("ooo_w%0d", w));
            bus.pe_data = {24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF};
            @(negedge clk);
            chk($sformatf("ooo_w%0d_done", w), 32'(done), (w == 0) ? 32'd0 : 32'd1);
            chk($sformatf("ooo_w%0d_busy", w), 32'(busy), (w == 0) ? 32'd1 : 32'd0);
        end

        // Back-pressure in OUT, with a flush that must be ignored there.
        tick();
        start         = 1'b1;
        cfg_shift     = 4'd0;
        cfg_num_words = 16'd2;
        bus.pe_data   = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
        tick();
        start        = 1'b0;
        bus.pe_valid = 4'hF;
        wait_word("hold", 20);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                tick();
                flush = (i == 4);
                @(negedge clk);
            end
            chk($sformatf("hold%0d_valid", i), 32'(bus.word_valid), 32'd1);
            chk($sformatf("hold%0d_data", i), bus.word_data, 32'h04030201);
            chk($sformatf("hold%0d_ready", i), 32'(bus.pe_ready), 32'd0);
            chk($sformatf("hold%0d_in_valid", i), 32'(bus.pk_in_valid), 32'd0);
        end
        accept("hold");
        @(negedge clk);
        chk("hold_next_lane0", 32'(bus.pe_ready), 32'd1);
        chk("hold_next_fire", 32'(bus.pk_in_valid), 32'd1);
        wait_word("hold2", 20);
        chk("hold2_word", bus.word_data, 32'h04030201);
        accept("hold2");
        bus.pe_valid = '0;
        @(negedge clk);
        chk("hold2_done", 32'(done), 32'd1);

        // Flush after two lanes pads the rest with zeros.
        tick();
        start         = 1'b1;
        cfg_shift     = 4'd0;
        cfg_num_words = 16'd3;
        bus.pe_data   = {24'h000055, 24'h000055, 24'hFFFFBB, 24'hFFFFAA};
        tick();
        start        = 1'b0;
        bus.pe_valid = 4'b0011;
        tick();
        tick();
        flush        = 1'b1;
        bus.pe_valid = 4'hF;
        @(negedge clk);
        chk("flush_ready", 32'(bus.pe_ready), 32'd0);
        chk("flush_in_valid", 32'(bus.pk_in_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            flush        = 1'b0;
            bus.pe_valid = '0;
            @(negedge clk);
            chk($sformatf("pad%0d_valid", i), 32'(bus.pk_in_valid), 32'd1);
            chk($sformatf("pad%0d_data", i), 32'(bus.pk_in_data), 32'd0);
        end
        wait_word("flush", 10);
        chk("flush_word", bus.word_data, 32'h0000BBAA);
        accept("flush");
        @(negedge clk);
        chk("flush_done", 32'(done), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);

        // Flush before any lane: job ends with no word.
        tick();
        start         = 1'b1;
        cfg_num_words = 16'd5;
        tick();
        start        = 1'b0;
        flush        = 1'b1;
        bus.pe_valid = 4'hF;
        @(negedge clk);
        chk("flush0_ready", 32'(bus.pe_ready), 32'd0);
        chk("flush0_in_valid", 32'(bus.pk_in_valid), 32'd0);
        tick();
        flush        = 1'b0;
        bus.pe_valid = '0;
        @(negedge clk);
        chk("flush0_done", 32'(done), 32'd1);
        chk("flush0_busy", 32'(busy), 32'd0);
        chk("flush0_word_valid", 32'(bus.word_valid), 32'd0);

        // Reset at lane 2, then a clean job.
        tick();
        start         = 1'b1;
        cfg_num_words = 16'd1;
        bus.pe_data   = {24'h000066, 24'h000066, 24'h000066, 24'h000066};
        tick();
        start        = 1'b0;
        bus.pe_valid = 4'b0011;
        tick();
        tick();
        bus.pe_valid = '0;
        @(negedge clk);
        chk("mid_lane2_ready", 32'(bus.pe_ready), 32'd4);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_clear", 32'(bus.pk_clear), 32'd1);
        chk("mid_rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.pe_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_word_valid", 32'(bus.word_valid), 32'd0);
        run_vec("after_rst", vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
